// File: rtl/dna_reader_pkg.sv
// dna_reader_pkg: shared constants and state encoding for the DNA_PORT sequencer
package dna_reader_pkg;
  localparam int DNA_WIDTH = 57;
  localparam int DNA_EDGES = 58;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} dna_state_t;
endpackage

// File: rtl/dna_clkgen.sv
// dna_clkgen: divides clk into the DNA_CLK level with one-cycle strobes on the cycle each edge is driven
module dna_clkgen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic run,
  output logic dna_clk,
  output logic rise_stb,
  output logic fall_stb
);
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [PW-1:0] phase;
  logic wrap;
  assign wrap = run && phase == PW'(CLK_DIV - 1);
  assign rise_stb = wrap && !dna_clk;
  assign fall_stb = wrap && dna_clk;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
      dna_clk <= 1'b0;
    end else if (restart) begin
      phase <= '0;
      dna_clk <= 1'b0;
    end else if (run) begin
      phase <= wrap ? '0 : phase + 1'b1;
      dna_clk <= dna_clk ^ wrap;
    end
  end
endmodule

// File: rtl/dna_port_sequencer.sv
// dna_port_sequencer: reads the 57-bit device DNA serially from DNA_PORT and presents it in parallel
module dna_port_sequencer
  import dna_reader_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter bit AUTO_READ = 1'b1
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        start,
  output logic        busy,
  output logic        dna_valid,
  output logic [56:0] dna_value,
  output logic [31:0] dna_word_lo,
  output logic [31:0] dna_word_hi,
  output logic        DNA_CLK,
  output logic        DNA_READ,
  output logic        DNA_SHIFT,
  output logic        DNA_DIN,
  input  logic        DNA_DOUT
);
  dna_state_t state, state_n;
  logic first, accept, run, capture, load_end, finish, rise, fall;
  logic [5:0] cnt;
  dna_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk(ACLK),
    .rst(ARESET),
    .restart(accept),
    .run(run),
    .dna_clk(DNA_CLK),
    .rise_stb(rise),
    .fall_stb(fall)
  );
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state == IDLE  ? (accept ? LOAD : IDLE) :
              state == LOAD  ? (load_end ? SHIFT : LOAD) :
              state == SHIFT ? (finish ? DONE : SHIFT) : IDLE;
  end
  always_comb begin
    accept = state == IDLE && (start || first);
    run = state == LOAD || state == SHIFT;
    load_end = state == LOAD && fall;
    capture = state == SHIFT && rise;
    finish = state == SHIFT && fall && cnt == 6'(DNA_WIDTH);
  end
  // DOUT is sampled on the same clk edge that raises DNA_CLK, before DNA_PORT shifts
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      first <= AUTO_READ;
      busy <= 1'b0;
      dna_valid <= 1'b0;
      dna_value <= '0;
      DNA_READ <= 1'b0;
      DNA_SHIFT <= 1'b0;
      cnt <= '0;
    end else begin
      first <= 1'b0;
      if (accept) begin
        busy <= 1'b1;
        dna_valid <= 1'b0;
        dna_value <= '0;
        DNA_READ <= 1'b1;
        cnt <= '0;
      end
      if (load_end) begin
        DNA_READ <= 1'b0;
        DNA_SHIFT <= 1'b1;
      end
      if (capture) begin
        dna_value <= {dna_value[55:0], DNA_DOUT};
        cnt <= cnt + 1'b1;
      end
      if (finish) begin
        DNA_SHIFT <= 1'b0;
        busy <= 1'b0;
        dna_valid <= 1'b1;
      end
    end
  end
  assign dna_word_lo = dna_value[31:0];
  assign dna_word_hi = {7'b0, dna_value[56:32]};
  assign DNA_DIN = 1'b0;
endmodule

// File: tb/tb_dna_port_sequencer.sv
// tb_dna_port_sequencer: scoreboard bench with behavioural DNA_PORT models for two divider settings
module tb_dna_port_sequencer;
  localparam logic [56:0] SIM_DNA_VALUE = 57'h0123456789ABCDE;
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  logic start_a = 1'b0, start_b = 1'b0;
  logic busy_a, valid_a, clk_a, read_a, shift_a, din_a, dout_a;
  logic busy_b, valid_b, clk_b, read_b, shift_b, din_b, dout_b;
  logic [56:0] value_a, value_b;
  logic [31:0] lo_a, hi_a, lo_b, hi_b;

  dna_port_sequencer #(.CLK_DIV(2), .AUTO_READ(1'b1)) dut_a (
    .ACLK(ACLK), .ARESET(ARESET), .start(start_a), .busy(busy_a), .dna_valid(valid_a),
    .dna_value(value_a), .dna_word_lo(lo_a), .dna_word_hi(hi_a), .DNA_CLK(clk_a),
    .DNA_READ(read_a), .DNA_SHIFT(shift_a), .DNA_DIN(din_a), .DNA_DOUT(dout_a)
  );
  dna_port_sequencer #(.CLK_DIV(1), .AUTO_READ(1'b0)) dut_b (
    .ACLK(ACLK), .ARESET(ARESET), .start(start_b), .busy(busy_b), .dna_valid(valid_b),
    .dna_value(value_b), .dna_word_lo(lo_b), .dna_word_hi(hi_b), .DNA_CLK(clk_b),
    .DNA_READ(read_b), .DNA_SHIFT(shift_b), .DNA_DIN(din_b), .DNA_DOUT(dout_b)
  );

  // behavioural DNA_PORT: parallel load or left shift on DNA_CLK rise, DOUT is the top bit
  logic [56:0] val_a = SIM_DNA_VALUE, val_b = 57'h0FEDCBA98765432;
  logic [56:0] sr_a = '0, sr_b = '0;
  always @(posedge clk_a) if (read_a) sr_a <= val_a; else if (shift_a) sr_a <= sr_a << 1;
  always @(posedge clk_b) if (read_b) sr_b <= val_b; else if (shift_b) sr_b <= sr_b << 1;
  assign dout_a = sr_a[56];
  assign dout_b = sr_b[56];

  int cyc = 0, rises_a = 0, reads_a = 0, rises_b = 0, reads_b = 0;
  always @(posedge ACLK) cyc <= cyc + 1;
  always @(posedge clk_a) rises_a <= rises_a + 1;
  always @(posedge read_a) reads_a <= reads_a + 1;
  always @(posedge clk_b) rises_b <= rises_b + 1;
  always @(posedge read_b) reads_b <= reads_b + 1;

  typedef struct { logic [56:0] val; logic [31:0] hi, lo; int due, rise0, read0; } rd_t;
  typedef struct { int at; int sel; logic [7:0] exp; string name; } pt_t;
  rd_t qa[$], qb[$];
  pt_t pq[$];
  int checks = 0, errors = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: point checks at their cycle, read results on each dna_valid rise
  logic pv_a = 1'b0, pv_b = 1'b0;
  always @(negedge ACLK) begin
    while (pq.size() != 0 && pq[0].at <= cyc) begin
      pt_t p;
      logic [7:0] act;
      p = pq.pop_front();
      act = p.sel == 0 ? {7'b0, valid_a} :
            p.sel == 1 ? {7'b0, busy_a} :
            p.sel == 2 ? {busy_a, valid_a, read_a, shift_a, clk_a, din_a, |value_a, |{hi_a, lo_a}} :
            {7'b0, clk_b};
      cmp(p.name, 64'(act), 64'(p.exp));
    end
    if (valid_a && !pv_a) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid_a: valid rose with no read pending (cycle %0d)", cyc);
      end else begin
        rd_t e;
        e = qa.pop_front();
        cmp("value_a", 64'(value_a), 64'(e.val));
        cmp("word_hi_a", 64'(hi_a), 64'(e.hi));
        cmp("word_lo_a", 64'(lo_a), 64'(e.lo));
        cmp("valid_cycle_a", 64'(cyc), 64'(e.due));
        cmp("dna_clk_rises_a", 64'(rises_a - e.rise0), 64'd58);
        cmp("dna_read_pulses_a", 64'(reads_a - e.read0), 64'd1);
      end
    end
    if (valid_b && !pv_b) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid_b: valid rose with no read pending (cycle %0d)", cyc);
      end else begin
        rd_t e;
        e = qb.pop_front();
        cmp("value_b", 64'(value_b), 64'(e.val));
        cmp("word_hi_b", 64'(hi_b), 64'(e.hi));
        cmp("word_lo_b", 64'(lo_b), 64'(e.lo));
        cmp("valid_cycle_b", 64'(cyc), 64'(e.due));
        cmp("dna_clk_rises_b", 64'(rises_b - e.rise0), 64'd58);
        cmp("dna_read_pulses_b", 64'(reads_b - e.read0), 64'd1);
      end
    end
    if (qa.size() != 0 && cyc > qa[0].due + 20) begin
      checks++;
      errors++;
      $display("FAIL timeout_a: no dna_valid by cycle %0d, expected at %0d", cyc, qa[0].due);
      void'(qa.pop_front());
    end
    if (qb.size() != 0 && cyc > qb[0].due + 20) begin
      checks++;
      errors++;
      $display("FAIL timeout_b: no dna_valid by cycle %0d, expected at %0d", cyc, qb[0].due);
      void'(qb.pop_front());
    end
    pv_a <= valid_a;
    pv_b <= valid_b;
  end

  task automatic expect_read(input bit b, input logic [56:0] v, input logic [31:0] hi, input logic [31:0] lo, input int lat);
    rd_t e;
    e.val = v;
    e.hi = hi;
    e.lo = lo;
    e.due = cyc + lat;
    e.rise0 = b ? rises_b : rises_a;
    e.read0 = b ? reads_b : reads_a;
    if (b) qb.push_back(e);
    else qa.push_back(e);
  endtask

  task automatic point(input int at, input int sel, input logic [7:0] exp, input string name);
    pt_t p;
    p.at = at;
    p.sel = sel;
    p.exp = exp;
    p.name = name;
    pq.push_back(p);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && qa.size() + qb.size() + pq.size() != 0; i++) tick();
    repeat (2) tick();
  endtask

  task automatic reset_pulse();
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
  endtask

  int s, base;
  initial begin
    repeat (3) tick();
    point(cyc, 2, 8'h00, "reset_state_a");
    // auto read after reset, with start pulses dropped while busy
    ARESET = 1'b0;
    s = cyc;
    point(s, 1, 8'h00, "busy_cycle0");
    point(s + 1, 1, 8'h01, "busy_cycle1");
    expect_read(1'b0, SIM_DNA_VALUE, 32'h00123456, 32'h789ABCDE, 233);
    wait_to(s + 10);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_to(s + 100);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    drain();
    // re-read with a new device value
    val_a = 57'h0AAAAAAAAAAAAAA;
    s = cyc;
    start_a = 1'b1;
    point(s + 1, 0, 8'h00, "valid_low_after_start");
    expect_read(1'b0, 57'h0AAAAAAAAAAAAAA, 32'h00AAAAAA, 32'hAAAAAAAA, 233);
    tick();
    start_a = 1'b0;
    drain();
    // extreme values, each re-run through reset
    val_a = 57'h1FFFFFFFFFFFFFF;
    reset_pulse();
    expect_read(1'b0, 57'h1FFFFFFFFFFFFFF, 32'h01FFFFFF, 32'hFFFFFFFF, 233);
    drain();
    val_a = '0;
    reset_pulse();
    expect_read(1'b0, 57'h0, 32'h0, 32'h0, 233);
    drain();
    // reset during rising edge 30 discards the partial value
    val_a = SIM_DNA_VALUE;
    reset_pulse();
    base = rises_a;
    for (int i = 0; i < 400 && rises_a < base + 30; i++) tick();
    ARESET = 1'b1;
    point(cyc, 2, 8'h00, "reset_mid_shift");
    tick();
    ARESET = 1'b0;
    expect_read(1'b0, SIM_DNA_VALUE, 32'h00123456, 32'h789ABCDE, 233);
    drain();
    // minimum divider, explicit start
    s = cyc;
    start_b = 1'b1;
    expect_read(1'b1, 57'h0FEDCBA98765432, 32'h00FEDCBA, 32'h98765432, 117);
    point(s + 2, 3, 8'h01, "dna_clk_b_rise1");
    point(s + 3, 3, 8'h00, "dna_clk_b_fall1");
    point(s + 4, 3, 8'h01, "dna_clk_b_rise2");
    tick();
    start_b = 1'b0;
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
